decode_stage: RTL and testbench

Single-entry RV32I decode stage between fetch and execute. Accepts an instruction over a valid/ready handshake, drives the register file's combinational read ports from the instruction's rs1/rs2 fields, and generates the immediate and control fields. It registers operands plus control into one output slot toward execute. A 32-entry busy scoreboard stalls read-after-write hazards until the register file write port retires the producing write.

---
 rtl/decode_stage.sv | 279 +++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// decode_stage: single-entry RV32I decode between fetch and execute.
// Decodes the offered instruction, reads the register file through the
// combinational read ports, and registers operands plus control fields into
// one output slot. A 32-entry busy scoreboard stalls read-after-write hazards
// until the register file write port retires the producing instruction.
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,

    // fetch side
    input  logic            i_if_valid,
    output logic            o_if_ready,
    input  logic [31:0]     i_if_instr,
    input  logic [XLEN-1:0] i_if_pc,

    // register file read ports
    output logic [4:0]      o_rs1_raddr,
    input  logic [XLEN-1:0] i_rs1_rdata,
    output logic [4:0]      o_rs2_raddr,
    input  logic [XLEN-1:0] i_rs2_rdata,

    // register file write port (retirement)
    input  logic            i_rd_wvalid,
    input  logic [4:0]      i_rd_waddr,

    // squash
    input  logic            i_flush,

    // execute side
    output logic            o_ex_valid,
    input  logic            i_ex_ready,
    output logic [XLEN-1:0] o_ex_pc,
    output logic [XLEN-1:0] o_ex_rs1_data,
    output logic [XLEN-1:0] o_ex_rs2_data,
    output logic [XLEN-1:0] o_ex_imm,
    output logic [6:0]      o_ex_opcode,
    output logic [2:0]      o_ex_funct3,
    output logic            o_ex_funct7b5,
    output logic [4:0]      o_ex_rd_addr,
    output logic            o_ex_rd_wen,
    output logic            o_ex_illegal
);

    // RV32I major opcodes
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [6:0] dec_opcode;
    logic [4:0] dec_rd;
    logic [4:0] dec_rs1;
    logic [4:0] dec_rs2;
    logic [2:0] dec_funct3;
    logic       dec_funct7b5;

    assign dec_opcode   = i_if_instr[6:0];
    assign dec_rd       = i_if_instr[11:7];
    assign dec_funct3   = i_if_instr[14:12];
    assign dec_rs1      = i_if_instr[19:15];
    assign dec_rs2      = i_if_instr[24:20];
    assign dec_funct7b5 = i_if_instr[30];

    // Read addresses follow the instruction word even when i_if_valid is low.
    assign o_rs1_raddr = dec_rs1;
    assign o_rs2_raddr = dec_rs2;

    // ------------------------------------------------------------------
    // Immediate formats (32-bit, sign bit is instr[31])
    // ------------------------------------------------------------------
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign imm_i = {{21{i_if_instr[31]}}, i_if_instr[30:20]};
    assign imm_s = {{21{i_if_instr[31]}}, i_if_instr[30:25], i_if_instr[11:7]};
    assign imm_b = {{20{i_if_instr[31]}}, i_if_instr[7], i_if_instr[30:25],
                    i_if_instr[11:8], 1'b0};
    assign imm_u = {i_if_instr[31:12], 12'h000};
    assign imm_j = {{12{i_if_instr[31]}}, i_if_instr[19:12], i_if_instr[20],
                    i_if_instr[30:21], 1'b0};

    // ------------------------------------------------------------------
    // Opcode class decode
    // ------------------------------------------------------------------
    logic        dec_uses_rs1;
    logic        dec_uses_rs2;
    logic        dec_writes_rd;
    logic        dec_illegal;
    logic [31:0] dec_imm32;
    logic        dec_rd_wen;
    logic [XLEN-1:0] dec_imm;

    // Classify the opcode: immediate format, source use and rd write.
    always_comb begin
        dec_uses_rs1  = 1'b0;
        dec_uses_rs2  = 1'b0;
        dec_writes_rd = 1'b0;
        dec_illegal   = 1'b0;
        dec_imm32     = 32'h0;
        case (dec_opcode)
            OPC_LUI, OPC_AUIPC: begin
                dec_imm32     = imm_u;
                dec_writes_rd = 1'b1;
            end
            OPC_JAL: begin
                dec_imm32     = imm_j;
                dec_writes_rd = 1'b1;
            end
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
                dec_imm32     = imm_i;
                dec_uses_rs1  = 1'b1;
                dec_writes_rd = 1'b1;
            end
            OPC_BRANCH: begin
                dec_imm32    = imm_b;
                dec_uses_rs1 = 1'b1;
                dec_uses_rs2 = 1'b1;
            end
            OPC_STORE: begin
                dec_imm32    = imm_s;
                dec_uses_rs1 = 1'b1;
                dec_uses_rs2 = 1'b1;
            end
            OPC_OP: begin
                dec_imm32     = 32'h0;
                dec_uses_rs1  = 1'b1;
                dec_uses_rs2  = 1'b1;
                dec_writes_rd = 1'b1;
            end
            OPC_MISC_MEM, OPC_SYSTEM: begin
                // I-type immediate is carried along; no register traffic.
                dec_imm32 = imm_i;
            end
            default: begin
                // Unknown opcodes travel to execute flagged, with no side effects.
                dec_illegal = 1'b1;
            end
        endcase
        // The quadrant bits are part of every legal opcode; flag them explicitly
        // so the intent survives if the opcode table ever changes.
        if (i_if_instr[1:0] != 2'b11) begin
            dec_illegal   = 1'b1;
            dec_uses_rs1  = 1'b0;
            dec_uses_rs2  = 1'b0;
            dec_writes_rd = 1'b0;
            dec_imm32     = 32'h0;
        end
    end

    assign dec_rd_wen = dec_writes_rd && (dec_rd != 5'd0);
    assign dec_imm    = {{(XLEN-31){dec_imm32[31]}}, dec_imm32[30:0]};

    // ------------------------------------------------------------------
    // Scoreboard and handshake
    // ------------------------------------------------------------------
    logic [31:0] busy_reg;
    logic [31:0] busy_next;
    logic        hazard;
    logic        accept;
    logic        flush_clr;

    logic            ex_valid_reg;
    logic            ex_valid_next;
    logic [XLEN-1:0] ex_pc_reg;
    logic [XLEN-1:0] ex_rs1_data_reg;
    logic [XLEN-1:0] ex_rs2_data_reg;
    logic [XLEN-1:0] ex_imm_reg;
    logic [6:0]      ex_opcode_reg;
    logic [2:0]      ex_funct3_reg;
    logic            ex_funct7b5_reg;
    logic [4:0]      ex_rd_addr_reg;
    logic            ex_rd_wen_reg;
    logic            ex_illegal_reg;

    // No write-to-read bypass: a retiring write unblocks the consumer one cycle
    // later, when the register file already returns the new value.
    assign hazard = (dec_uses_rs1 && busy_reg[dec_rs1]) ||
                    (dec_uses_rs2 && busy_reg[dec_rs2]);

    assign o_if_ready = (!ex_valid_reg || i_ex_ready) && !hazard && !i_flush;
    assign accept     = i_if_valid && o_if_ready;

    // A flushed instruction never retires, so its pending write is released here.
    assign flush_clr = i_flush && ex_valid_reg && ex_rd_wen_reg;

    // x0 is never busy.
    assign busy_next[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_busy
            logic set_bit;
            logic clr_bit;
            assign set_bit = accept && dec_rd_wen && (dec_rd == 5'(gi));
            assign clr_bit = (i_rd_wvalid && (i_rd_waddr == 5'(gi))) ||
                             (flush_clr && (ex_rd_addr_reg == 5'(gi)));
            // Set beats clear: the newly accepted writer is younger than the
            // one retiring.
            assign busy_next[gi] = set_bit || (busy_reg[gi] && !clr_bit);
        end
    endgenerate

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy_reg <= 32'h0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    // Output slot occupancy: fill on accept, empty on consume or flush.
    always_comb begin
        ex_valid_next = ex_valid_reg;
        if (accept) begin
            ex_valid_next = 1'b1;
        end else if (i_flush || i_ex_ready) begin
            ex_valid_next = 1'b0;
        end
    end

    // Output slot register; payload loads only on accept and otherwise holds.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ex_valid_reg    <= 1'b0;
            ex_pc_reg       <= '0;
            ex_rs1_data_reg <= '0;
            ex_rs2_data_reg <= '0;
            ex_imm_reg      <= '0;
            ex_opcode_reg   <= 7'h0;
            ex_funct3_reg   <= 3'h0;
            ex_funct7b5_reg <= 1'b0;
            ex_rd_addr_reg  <= 5'h0;
            ex_rd_wen_reg   <= 1'b0;
            ex_illegal_reg  <= 1'b0;
        end else begin
            ex_valid_reg <= ex_valid_next;
            if (accept) begin
                ex_pc_reg       <= i_if_pc;
                ex_rs1_data_reg <= i_rs1_rdata;
                ex_rs2_data_reg <= i_rs2_rdata;
                ex_imm_reg      <= dec_imm;
                ex_opcode_reg   <= dec_opcode;
                ex_funct3_reg   <= dec_funct3;
                ex_funct7b5_reg <= dec_funct7b5;
                ex_rd_addr_reg  <= dec_rd;
                ex_rd_wen_reg   <= dec_rd_wen;
                ex_illegal_reg  <= dec_illegal;
            end
        end
    end

    assign o_ex_valid    = ex_valid_reg;
    assign o_ex_pc       = ex_pc_reg;
    assign o_ex_rs1_data = ex_rs1_data_reg;
    assign o_ex_rs2_data = ex_rs2_data_reg;
    assign o_ex_imm      = ex_imm_reg;
    assign o_ex_opcode   = ex_opcode_reg;
    assign o_ex_funct3   = ex_funct3_reg;
    assign o_ex_funct7b5 = ex_funct7b5_reg;
    assign o_ex_rd_addr  = ex_rd_addr_reg;
    assign o_ex_rd_wen   = ex_rd_wen_reg;
    assign o_ex_illegal  = ex_illegal_reg;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scenarios followed by randomized traffic, all
// checked every cycle against a behavioural model of the decode stage.
module tb_decode_stage;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rstn;
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic [4:0]      rs1_raddr;
    logic [XLEN-1:0] rs1_rdata;
    logic [4:0]      rs2_raddr;
    logic [XLEN-1:0] rs2_rdata;
    logic            rd_wvalid;
    logic [4:0]      rd_waddr;
    logic [31:0]     rd_wdata;
    logic            flush;
    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_rs1_data;
    logic [XLEN-1:0] ex_rs2_data;
    logic [XLEN-1:0] ex_imm;
    logic [6:0]      ex_opcode;
    logic [2:0]      ex_funct3;
    logic            ex_funct7b5;
    logic [4:0]      ex_rd_addr;
    logic            ex_rd_wen;
    logic            ex_illegal;

    // Bench-owned register file, read combinationally by the DUT.
    logic [31:0] rf [32];
    assign rs1_rdata = rf[rs1_raddr];
    assign rs2_rdata = rf[rs2_raddr];

    decode_stage #(.XLEN(XLEN)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .i_if_valid    (if_valid),
        .o_if_ready    (if_ready),
        .i_if_instr    (if_instr),
        .i_if_pc       (if_pc),
        .o_rs1_raddr   (rs1_raddr),
        .i_rs1_rdata   (rs1_rdata),
        .o_rs2_raddr   (rs2_raddr),
        .i_rs2_rdata   (rs2_rdata),
        .i_rd_wvalid   (rd_wvalid),
        .i_rd_waddr    (rd_waddr),
        .i_flush       (flush),
        .o_ex_valid    (ex_valid),
        .i_ex_ready    (ex_ready),
        .o_ex_pc       (ex_pc),
        .o_ex_rs1_data (ex_rs1_data),
        .o_ex_rs2_data (ex_rs2_data),
        .o_ex_imm      (ex_imm),
        .o_ex_opcode   (ex_opcode),
        .o_ex_funct3   (ex_funct3),
        .o_ex_funct7b5 (ex_funct7b5),
        .o_ex_rd_addr  (ex_rd_addr),
        .o_ex_rd_wen   (ex_rd_wen),
        .o_ex_illegal  (ex_illegal)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    typedef struct packed {
        bit          u1;
        bit          u2;
        bit          wr;
        bit          ill;
        logic [31:0] imm;
    } dec_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        logic [4:0]  rd;
        logic        wen;
        logic        ill;
    } slot_t;

    slot_t       m_slot;
    logic [31:0] m_busy;
    bit          m_acc;
    int          retire_q[$];

    // Immediates computed as two's-complement weighted sums of the bit fields.
    function automatic dec_t ref_decode(input logic [31:0] ins);
        dec_t d;
        int i_imm, s_imm, b_imm, j_imm;
        d = '0;
        i_imm = int'(ins[30:20]) - (ins[31] ? 2048 : 0);
        s_imm = int'(ins[30:25]) * 32 + int'(ins[11:7]) - (ins[31] ? 2048 : 0);
        b_imm = int'(ins[11:8]) * 2 + int'(ins[30:25]) * 32 + int'(ins[7]) * 2048
                - (ins[31] ? 4096 : 0);
        j_imm = int'(ins[30:21]) * 2 + int'(ins[20]) * 2048 + int'(ins[19:12]) * 4096
                - (ins[31] ? 1048576 : 0);
        case (ins[6:0])
            7'h37, 7'h17: begin d.imm = ins & 32'hFFFFF000; d.wr = 1; end
            7'h6F:        begin d.imm = j_imm; d.wr = 1; end
            7'h67, 7'h03, 7'h13: begin d.imm = i_imm; d.u1 = 1; d.wr = 1; end
            7'h63:        begin d.imm = b_imm; d.u1 = 1; d.u2 = 1; end
            7'h23:        begin d.imm = s_imm; d.u1 = 1; d.u2 = 1; end
            7'h33:        begin d.imm = 0; d.u1 = 1; d.u2 = 1; d.wr = 1; end
            7'h0F, 7'h73: begin d.imm = i_imm; end
            default:      begin d.ill = 1; end
        endcase
        return d;
    endfunction

    function automatic bit model_ready();
        dec_t d;
        bit hz;
        d  = ref_decode(if_instr);
        hz = (d.u1 && m_busy[if_instr[19:15]]) || (d.u2 && m_busy[if_instr[24:20]]);
        return (!m_slot.valid || ex_ready) && !hz && !flush;
    endfunction

    // Called at each rising edge, before the bench changes any input.
    task automatic model_advance();
        dec_t        d;
        logic [31:0] nb;
        bit          acc;
        d   = ref_decode(if_instr);
        acc = 1'b0;
        if (!rstn) begin
            m_slot = '0;
            m_busy = '0;
            retire_q.delete();
        end else begin
            acc = if_valid && model_ready();
            nb  = m_busy;
            if (rd_wvalid) nb[rd_waddr] = 1'b0;
            if (flush && m_slot.valid && m_slot.wen) nb[m_slot.rd] = 1'b0;
            if (acc && d.wr && if_instr[11:7] != 5'd0) nb[if_instr[11:7]] = 1'b1;
            nb[0] = 1'b0;
            if (m_slot.valid && ex_ready && !flush && m_slot.wen)
                retire_q.push_back(int'(m_slot.rd));
            if (acc) begin
                m_slot.valid = 1'b1;
                m_slot.pc    = if_pc;
                m_slot.rs1   = rf[if_instr[19:15]];
                m_slot.rs2   = rf[if_instr[24:20]];
                m_slot.imm   = d.imm;
                m_slot.opc   = if_instr[6:0];
                m_slot.f3    = if_instr[14:12];
                m_slot.f7    = if_instr[30];
                m_slot.rd    = if_instr[11:7];
                m_slot.wen   = d.wr && (if_instr[11:7] != 5'd0);
                m_slot.ill   = d.ill;
                $display("accept pc=%h instr=%h imm=%h rd=%0d wen=%0b ill=%0b",
                         if_pc, if_instr, d.imm, if_instr[11:7], m_slot.wen, d.ill);
            end else if (flush || ex_ready) begin
                m_slot.valid = 1'b0;
            end
            m_busy = nb;
        end
        if (rd_wvalid && rd_waddr != 5'd0) rf[rd_waddr] <= rd_wdata;
        m_acc = acc;
    endtask

    // Compare every DUT output against the model in the middle of each cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("if_ready",  {31'b0, if_ready}, {31'b0, model_ready()});
            check("rs1_raddr", {27'b0, rs1_raddr}, {27'b0, if_instr[19:15]});
            check("rs2_raddr", {27'b0, rs2_raddr}, {27'b0, if_instr[24:20]});
            check("ex_valid",  {31'b0, ex_valid}, {31'b0, m_slot.valid});
            check("ex_pc",     ex_pc, m_slot.pc);
            check("ex_rs1",    ex_rs1_data, m_slot.rs1);
            check("ex_rs2",    ex_rs2_data, m_slot.rs2);
            check("ex_imm",    ex_imm, m_slot.imm);
            check("ex_opcode", {25'b0, ex_opcode}, {25'b0, m_slot.opc});
            check("ex_funct3", {29'b0, ex_funct3}, {29'b0, m_slot.f3});
            check("ex_f7b5",   {31'b0, ex_funct7b5}, {31'b0, m_slot.f7});
            check("ex_rd",     {27'b0, ex_rd_addr}, {27'b0, m_slot.rd});
            check("ex_rd_wen", {31'b0, ex_rd_wen}, {31'b0, m_slot.wen});
            check("ex_ill",    {31'b0, ex_illegal}, {31'b0, m_slot.ill});
            check("busy",      dut.busy_reg, m_busy);
        end
    end

    task automatic cycle();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        w        = $urandom();
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        w[11:7]  = 5'($urandom_range(0, 7));
        k        = $urandom_range(0, 12);
        case (k)
            0:  w[6:0] = 7'h37;
            1:  w[6:0] = 7'h17;
            2:  w[6:0] = 7'h6F;
            3:  w[6:0] = 7'h67;
            4:  w[6:0] = 7'h63;
            5:  w[6:0] = 7'h03;
            6:  w[6:0] = 7'h23;
            7:  w[6:0] = 7'h13;
            8:  w[6:0] = 7'h33;
            9:  w[6:0] = 7'h0F;
            10: w[6:0] = 7'h73;
            11: w[6:0] = 7'($urandom());
            default: begin w[6:0] = 7'h13; w[1:0] = 2'($urandom_range(0, 2)); end
        endcase
        return w;
    endfunction

    initial begin
        bit offered;
        for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i) * 32'h111;
        m_slot    = '0;
        m_busy    = '0;
        m_acc     = 1'b0;
        rstn      = 1'b0;
        if_valid  = 1'b0;
        if_instr  = 32'h0;
        if_pc     = 32'h0;
        rd_wvalid = 1'b0;
        rd_waddr  = 5'd0;
        rd_wdata  = 32'h0;
        flush     = 1'b0;
        ex_ready  = 1'b1;

        // Reset
        cycle();
        chk_en = 1'b1;
        cycle();
        rstn = 1'b1;
        @(negedge clk);
        check("rst_ex_valid", {31'b0, ex_valid}, 32'h0);
        check("rst_ex_pc", ex_pc, 32'h0);
        check("rst_ex_imm", ex_imm, 32'h0);
        check("rst_if_ready", {31'b0, if_ready}, 32'h1);
        check("rst_busy", dut.busy_reg, 32'h0);

        // ADDI x1,x0,5 at 0x100
        if_valid = 1'b1; if_instr = 32'h00500093; if_pc = 32'h100;
        cycle();
        if_instr = 32'h00108133; if_pc = 32'h104;          // ADD x2,x1,x1
        @(negedge clk);
        check("addi_valid", {31'b0, ex_valid}, 32'h1);
        check("addi_imm", ex_imm, 32'h5);
        check("addi_rd", {27'b0, ex_rd_addr}, 32'h1);
        check("addi_wen", {31'b0, ex_rd_wen}, 32'h1);
        check("addi_busy1", {31'b0, dut.busy_reg[1]}, 32'h1);
        check("raw_stall1", {31'b0, if_ready}, 32'h0);
        cycle();
        @(negedge clk);
        check("raw_stall2", {31'b0, if_ready}, 32'h0);
        rd_wvalid = 1'b1; rd_waddr = 5'd1; rd_wdata = 32'hDEADBEEF;
        #1;
        check("raw_stall_wcycle", {31'b0, if_ready}, 32'h0);
        cycle();
        rd_wvalid = 1'b0;
        @(negedge clk);
        check("raw_release", {31'b0, if_ready}, 32'h1);
        cycle();
        if_instr = 32'hFE000EE3; if_pc = 32'h108;           // BEQ x0,x0,-4
        @(negedge clk);
        check("add_rs1", ex_rs1_data, 32'hDEADBEEF);
        check("add_rs2", ex_rs2_data, 32'hDEADBEEF);
        check("add_rd", {27'b0, ex_rd_addr}, 32'h2);
        cycle();
        if_instr = 32'h00700193; if_pc = 32'h10C;           // ADDI x3,x0,7
        @(negedge clk);
        check("beq_imm", ex_imm, 32'hFFFFFFFC);
        check("beq_wen", {31'b0, ex_rd_wen}, 32'h0);
        check("beq_busy", dut.busy_reg, 32'h0000_0004);
        cycle();
        // Second ADDI x3 accepted while x3 retires in the same cycle
        if_pc = 32'h110;
        rd_wvalid = 1'b1; rd_waddr = 5'd3; rd_wdata = 32'h33;
        @(negedge clk);
        check("setclr_ready", {31'b0, if_ready}, 32'h1);
        cycle();
        rd_wvalid = 1'b0;
        @(negedge clk);
        check("setclr_busy3", {31'b0, dut.busy_reg[3]}, 32'h1);

        // LUI x5,0x12345 held by execute back-pressure, then flushed
        if_instr = 32'h123452B7; if_pc = 32'h114;
        cycle();
        ex_ready = 1'b0;
        if_instr = 32'h00100313; if_pc = 32'h118;           // ADDI x6,x0,1
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold_imm", ex_imm, 32'h12345000);
            check("hold_pc", ex_pc, 32'h114);
            check("hold_rd", {27'b0, ex_rd_addr}, 32'h5);
            check("hold_ready", {31'b0, if_ready}, 32'h0);
            cycle();
        end
        flush = 1'b1;
        @(negedge clk);
        check("flush_ready", {31'b0, if_ready}, 32'h0);
        cycle();
        flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
        @(negedge clk);
        check("flush_valid", {31'b0, ex_valid}, 32'h0);
        check("flush_busy5", {31'b0, dut.busy_reg[5]}, 32'h0);

        // Illegal opcode, ADDI x0, ADD x6 back-to-back
        if_valid = 1'b1; if_instr = 32'h0000007F; if_pc = 32'h200;
        cycle();
        if_instr = 32'h00100013; if_pc = 32'h204;
        @(negedge clk);
        check("ill_flag", {31'b0, ex_illegal}, 32'h1);
        check("ill_wen", {31'b0, ex_rd_wen}, 32'h0);
        cycle();
        if_instr = 32'h00000333; if_pc = 32'h208;
        @(negedge clk);
        check("x0_wen", {31'b0, ex_rd_wen}, 32'h0);
        check("x0_ill", {31'b0, ex_illegal}, 32'h0);
        check("b2b_ready", {31'b0, if_ready}, 32'h1);
        cycle();
        ex_ready = 1'b0;
        if_instr = 32'h006303B3; if_pc = 32'h20C;           // ADD x7,x6,x6
        @(negedge clk);
        check("add6_rd", {27'b0, ex_rd_addr}, 32'h6);
        check("add6_wen", {31'b0, ex_rd_wen}, 32'h1);
        check("add6_busy", dut.busy_reg, 32'h0000_004C);

        // Reset while the slot is stalled
        cycle();
        rstn = 1'b0;
        cycle();
        rstn = 1'b1; if_valid = 1'b0; ex_ready = 1'b1;
        @(negedge clk);
        check("rst2_valid", {31'b0, ex_valid}, 32'h0);
        check("rst2_busy", dut.busy_reg, 32'h0);
        check("rst2_imm", ex_imm, 32'h0);

        // Randomized traffic
        offered = 1'b0;
        repeat (3000) begin
            if (!offered || m_acc) begin
                if ($urandom_range(0, 4) != 0) begin
                    if_instr = rand_instr();
                    if_pc    = $urandom() & 32'hFFFF_FFFC;
                    if_valid = 1'b1;
                    offered  = 1'b1;
                end else begin
                    if_instr = $urandom();
                    if_valid = 1'b0;
                    offered  = 1'b0;
                end
            end
            flush    = ($urandom_range(0, 29) == 0);
            ex_ready = flush ? 1'b0 : ($urandom_range(0, 9) < 7);
            if (retire_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                int idx;
                idx       = $urandom_range(0, retire_q.size() - 1);
                rd_waddr  = 5'(retire_q[idx]);
                retire_q.delete(idx);
                rd_wvalid = 1'b1;
            end else if ($urandom_range(0, 9) == 0) begin
                rd_waddr  = 5'($urandom_range(0, 31));
                rd_wvalid = 1'b1;
            end else begin
                rd_waddr  = 5'($urandom_range(0, 31));
                rd_wvalid = 1'b0;
            end
            rd_wdata = $urandom();
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
